// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// Pipeline register between the ID and EX stages of the 5-stage ARM core.
// Captures the decoded control, the operand values and the shifter fields, and
// feeds the EX-stage operand-2 generator and the ALU. Freeze holds the stage
// and flush inserts a full bubble. Two saturating counters track how many
// stall and flush cycles have occurred, for performance debug.
//
// Ports
//   clk, rst           pipeline clock; synchronous active-high reset
//   freeze             hazard stall, holds the whole stage
//   flush              branch taken, loads a bubble (wins over freeze)
//   cnt_clr            synchronous clear of both event counters
//   id_*               decoded instruction from the ID stage
//   ex_*               registered copies of the id_* inputs
//   ex_mem_cmd         registered (id_mem_r_en | id_mem_w_en)
//   stall_cnt          saturating count of freeze-only cycles
//   flush_cnt          saturating count of flush cycles
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mem_w_en,
  input  logic              id_b,
  input  logic              id_s,
  input  logic [3:0]        id_exe_cmd,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic              id_imm,
  input  logic [11:0]       id_shift_operand,
  input  logic [23:0]       id_signed_imm_24,
  input  logic [3:0]        id_dest,
  input  logic [3:0]        id_src1,
  input  logic [3:0]        id_src2,
  input  logic [3:0]        id_sr,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic [3:0]        ex_exe_cmd,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic              ex_imm,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [3:0]        ex_sr,
  output logic              ex_mem_cmd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage register. Flush outranks freeze so a taken branch always squashes
  // the instruction sitting in the stage, even while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid         <= 1'b0;
      ex_pc            <= '0;
      ex_wb_en         <= 1'b0;
      ex_mem_r_en      <= 1'b0;
      ex_mem_w_en      <= 1'b0;
      ex_b             <= 1'b0;
      ex_s             <= 1'b0;
      ex_exe_cmd       <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_imm           <= 1'b0;
      ex_shift_operand <= '0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_src1          <= '0;
      ex_src2          <= '0;
      ex_sr            <= '0;
      ex_mem_cmd       <= 1'b0;
    end else if (!freeze) begin
      // An invalid slot must not cause side effects, so its control bits are
      // squashed while the data fields still load as-is.
      ex_valid         <= id_valid;
      ex_pc            <= id_pc;
      ex_wb_en         <= id_valid & id_wb_en;
      ex_mem_r_en      <= id_valid & id_mem_r_en;
      ex_mem_w_en      <= id_valid & id_mem_w_en;
      ex_b             <= id_valid & id_b;
      ex_s             <= id_valid & id_s;
      ex_exe_cmd       <= id_exe_cmd;
      ex_val_rn        <= id_val_rn;
      ex_val_rm        <= id_val_rm;
      ex_imm           <= id_imm;
      ex_shift_operand <= id_shift_operand;
      ex_signed_imm_24 <= id_signed_imm_24;
      ex_dest          <= id_dest;
      ex_src1          <= id_src1;
      ex_src2          <= id_src2;
      ex_sr            <= id_sr;
      ex_mem_cmd       <= id_valid & (id_mem_r_en | id_mem_w_en);
    end
  end

  // Event counters. A flush+freeze cycle is counted as a flush only, and a
  // clear in the same cycle as an event drops that event.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end else if (freeze) begin
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Self-checking bench for id_ex_stage_reg, built with CNT_W=4 so counter
// saturation is reachable quickly. A table of directed vectors with explicit
// expected values covers reset, load, freeze, flush and invalid issue; short
// hand sequences cover saturation and clear; a randomized run is compared
// against a behavioural model of the stage and counters.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
    logic        mem_cmd;
  } stage_t;

  typedef struct {
    logic        rst, flush, freeze, clr;
    logic [31:0] pc;
    logic        valid, wb, mw, s, b;
    logic [31:0] rm, rn;
    logic [11:0] shop;
    logic [31:0] e_pc;
    logic        e_valid, e_wb, e_mc, e_s, e_b;
    logic [31:0] e_rm, e_rn;
    logic [11:0] e_shop;
    logic [3:0]  e_stall, e_flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, cnt_clr;
  stage_t id;
  stage_t act;
  stage_t exp_stage;
  int exp_stall, exp_flush;
  int checks = 0;
  int failures = 0;

  logic              ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
  logic              ex_imm, ex_mem_cmd;
  logic [DATA_W-1:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [3:0]        ex_exe_cmd, ex_dest, ex_src1, ex_src2, ex_sr;
  logic [11:0]       ex_shift_operand;
  logic [23:0]       ex_signed_imm_24;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr),
    .id_valid(id.valid), .id_pc(id.pc), .id_wb_en(id.wb_en),
    .id_mem_r_en(id.mem_r_en), .id_mem_w_en(id.mem_w_en), .id_b(id.b),
    .id_s(id.s), .id_exe_cmd(id.exe_cmd), .id_val_rn(id.val_rn),
    .id_val_rm(id.val_rm), .id_imm(id.imm), .id_shift_operand(id.shift_operand),
    .id_signed_imm_24(id.signed_imm_24), .id_dest(id.dest), .id_src1(id.src1),
    .id_src2(id.src2), .id_sr(id.sr),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b),
    .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd), .ex_val_rn(ex_val_rn),
    .ex_val_rm(ex_val_rm), .ex_imm(ex_imm), .ex_shift_operand(ex_shift_operand),
    .ex_signed_imm_24(ex_signed_imm_24), .ex_dest(ex_dest), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_sr(ex_sr), .ex_mem_cmd(ex_mem_cmd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act = {ex_valid, ex_pc, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s,
                ex_exe_cmd, ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand,
                ex_signed_imm_24, ex_dest, ex_src1, ex_src2, ex_sr, ex_mem_cmd};

  // What the EX stage should see after loading an instruction.
  function automatic stage_t loadedValue(stage_t in);
    stage_t r;
    r = in;
    r.mem_cmd = in.mem_r_en | in.mem_w_en;
    if (!in.valid) begin
      r.wb_en = 1'b0;
      r.mem_r_en = 1'b0;
      r.mem_w_en = 1'b0;
      r.b = 1'b0;
      r.s = 1'b0;
      r.mem_cmd = 1'b0;
    end
    return r;
  endfunction

  function automatic int satInc(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Drive one cycle of inputs, advance the model on the edge and sample #1 later.
  task automatic applyStimulus(input logic r, input logic fl, input logic fr,
                               input logic clr, input stage_t in);
    rst = r;
    flush = fl;
    freeze = fr;
    cnt_clr = clr;
    id = in;
    @(posedge clk);
    if (r) begin
      exp_stage = '0;
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (fl) exp_stage = '0;
      else if (!fr) exp_stage = loadedValue(in);
      if (clr) begin
        exp_stall = 0;
        exp_flush = 0;
      end else if (fl) exp_flush = satInc(exp_flush);
      else if (fr) exp_stall = satInc(exp_stall);
    end
    #1;
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if (act !== exp_stage) begin
      failures++;
      $display("[TB] FAIL %s stage: got %h expected %h", name, act, exp_stage);
    end
    checks++;
    if (int'(stall_cnt) != exp_stall) begin
      failures++;
      $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (int'(flush_cnt) != exp_flush) begin
      failures++;
      $display("[TB] FAIL %s flush_cnt: got %0d expected %0d", name, flush_cnt, exp_flush);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  vec_t vecs[15];
  stage_t base;
  stage_t rnd;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    freeze = 1'b0;
    cnt_clr = 1'b0;
    id = '0;
    exp_stage = '0;
    exp_stall = 0;
    exp_flush = 0;

    vecs[0]  = '{1,0,0,0, 32'h100,1,1,1,1,1, 32'hDEAD0000,32'h1111,12'hFFF, 32'h0,0,0,0,0,0, 32'h0,32'h0,12'h0, 0,0};
    vecs[1]  = '{1,1,1,0, 32'h104,1,1,1,1,1, 32'hDEAD0001,32'h2222,12'hABC, 32'h0,0,0,0,0,0, 32'h0,32'h0,12'h0, 0,0};
    vecs[2]  = '{0,0,0,0, 32'h10,1,0,0,0,0, 32'h0,32'h0,12'h0, 32'h10,1,0,0,0,0, 32'h0,32'h0,12'h0, 0,0};
    vecs[3]  = '{0,0,0,0, 32'h14,1,1,1,0,0, 32'hDEADBEEF,32'h3,12'h3A5, 32'h14,1,1,1,0,0, 32'hDEADBEEF,32'h3,12'h3A5, 0,0};
    vecs[4]  = '{0,0,0,0, 32'h20,1,0,0,0,0, 32'h11,32'h4,12'h001, 32'h20,1,0,0,0,0, 32'h11,32'h4,12'h001, 0,0};
    vecs[5]  = '{0,0,1,0, 32'h24,1,1,1,1,1, 32'h99,32'h5,12'h002, 32'h20,1,0,0,0,0, 32'h11,32'h4,12'h001, 1,0};
    vecs[6]  = '{0,0,1,0, 32'h24,1,1,1,1,1, 32'h99,32'h5,12'h002, 32'h20,1,0,0,0,0, 32'h11,32'h4,12'h001, 2,0};
    vecs[7]  = '{0,0,1,0, 32'h24,1,1,1,1,1, 32'h99,32'h5,12'h002, 32'h20,1,0,0,0,0, 32'h11,32'h4,12'h001, 3,0};
    vecs[8]  = '{0,0,0,0, 32'h24,1,1,1,1,1, 32'h99,32'h5,12'h002, 32'h24,1,1,1,1,1, 32'h99,32'h5,12'h002, 3,0};
    vecs[9]  = '{0,1,1,0, 32'h28,1,1,0,0,0, 32'h77,32'h6,12'h003, 32'h0,0,0,0,0,0, 32'h0,32'h0,12'h0, 3,1};
    vecs[10] = '{0,0,0,0, 32'h2C,0,1,1,1,1, 32'h55,32'hCAFE0001,12'h7FF, 32'h2C,0,0,0,0,0, 32'h55,32'hCAFE0001,12'h7FF, 3,1};
    vecs[11] = '{0,0,1,1, 32'h30,1,1,1,1,1, 32'h66,32'h7,12'h004, 32'h2C,0,0,0,0,0, 32'h55,32'hCAFE0001,12'h7FF, 0,0};
    vecs[12] = '{0,0,1,0, 32'h30,1,1,1,1,1, 32'h66,32'h7,12'h004, 32'h2C,0,0,0,0,0, 32'h55,32'hCAFE0001,12'h7FF, 1,0};
    vecs[13] = '{1,0,1,0, 32'h30,1,1,1,1,1, 32'h66,32'h7,12'h004, 32'h0,0,0,0,0,0, 32'h0,32'h0,12'h0, 0,0};
    vecs[14] = '{0,0,0,0, 32'h30,1,1,1,1,1, 32'h66,32'h7,12'h004, 32'h30,1,1,1,1,1, 32'h66,32'h7,12'h004, 0,0};

    base = '0;
    base.exe_cmd = 4'h9;
    base.signed_imm_24 = 24'h0ABCDE;
    base.dest = 4'h3;
    base.src1 = 4'h5;
    base.src2 = 4'h7;
    base.sr = 4'hA;

    $display("[TB] directed vectors");
    for (int i = 0; i < 15; i++) begin
      stage_t in;
      logic [140:0] got, want;
      in = base;
      in.pc = vecs[i].pc;
      in.valid = vecs[i].valid;
      in.wb_en = vecs[i].wb;
      in.mem_w_en = vecs[i].mw;
      in.s = vecs[i].s;
      in.b = vecs[i].b;
      in.val_rm = vecs[i].rm;
      in.val_rn = vecs[i].rn;
      in.shift_operand = vecs[i].shop;
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].freeze, vecs[i].clr, in);
      got  = {ex_pc, ex_valid, ex_wb_en, ex_mem_cmd, ex_s, ex_b, ex_val_rm, ex_val_rn,
              ex_shift_operand, stall_cnt, flush_cnt};
      want = {vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_wb, vecs[i].e_mc, vecs[i].e_s,
              vecs[i].e_b, vecs[i].e_rm, vecs[i].e_rn, vecs[i].e_shop,
              vecs[i].e_stall, vecs[i].e_flush};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL vec%0d: got %h expected %h", i, got, want);
      end
      checkOutput($sformatf("vec%0d_model", i));
    end

    $display("[TB] stall saturation and clear");
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0, base);
    checkCount("stall_sat", int'(stall_cnt), 15);
    checkOutput("stall_sat_model");
    applyStimulus(0, 0, 1, 1, base);
    checkCount("stall_clr", int'(stall_cnt), 0);
    applyStimulus(0, 0, 1, 0, base);
    checkCount("stall_recount", int'(stall_cnt), 1);

    $display("[TB] flush saturation");
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, (i % 2) == 1, 0, base);
    checkCount("flush_sat", int'(flush_cnt), 15);
    checkCount("flush_sat_stall", int'(stall_cnt), 1);
    checkOutput("flush_sat_model");

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      rnd = stage_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), rnd);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
